tbu_param: RTL

- Parametrised traceback unit for the Viterbi decoder. Replaces the fixed 8-state traceback unit.
- On a start pulse it walks backwards through the survivor (decision) memory from a given column and start state.
- It first discards TB_LEN training columns, then emits DEC_LEN decoded bits.
- Sits between the ACS/survivor memory and the output bit buffer.

---
 rtl/tbu_pkg.sv | 28 ++
 rtl/tbu_lifo.sv | 38 +++
 rtl/tbu_param.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/tbu_pkg.sv
// Shared types, defaults and trellis helpers for the parametrised traceback unit.
// TBU_PARAM_REVERSE_EN adds the DRAIN state used by the forward-order output LIFO.
package tbu_pkg;

  localparam int unsigned DefK      = 4;
  localparam int unsigned DefDepth  = 64;
  localparam int unsigned DefTbLen  = 16;
  localparam int unsigned DefDecLen = 16;
  // Widest state register the helper functions are written for.
  localparam int unsigned MaxSw     = 16;

`ifdef TBU_PARAM_REVERSE_EN
  typedef enum logic [1:0] {StIdle, StTrain, StDecode, StDrain} tbu_state_e;
`else
  typedef enum logic [1:0] {StIdle, StTrain, StDecode} tbu_state_e;
`endif

  function automatic int unsigned nstates(input int unsigned k);
    return 1 << (k - 1);
  endfunction

  // Predecessor state: shift the decision bit in at the LSB; caller truncates to its width.
  function automatic logic [MaxSw-1:0] prev_state(input logic [MaxSw-1:0] state,
                                                  input logic             dec);
    return {state[MaxSw-2:0], dec};
  endfunction

endpackage

// File: rtl/tbu_lifo.sv
// Single-bit LIFO used to reverse traceback output into forward-time order.
// Push and pop are never asserted together; flush clears all entries.
module tbu_lifo import tbu_pkg::*; #(
  parameter int unsigned DEPTH = DefDecLen
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  logic flush,
  input  logic din,
  output logic dout
);

  // Entry 0 is the top of stack; push shifts up, pop shifts down.
  logic [DEPTH-1:0] mem_q, mem_d;

  always_comb begin
    mem_d = mem_q;
    if (flush) begin
      mem_d = '0;
    end else if (push) begin
      mem_d[0] = din;
      for (int unsigned i = 1; i < DEPTH; i++) mem_d[i] = mem_q[i-1];
    end else if (pop) begin
      mem_d[DEPTH-1] = 1'b0;
      for (int unsigned i = 0; i + 1 < DEPTH; i++) mem_d[i] = mem_q[i+1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) mem_q <= '0;
    else      mem_q <= mem_d;
  end

  assign dout = mem_q[0];

endmodule

// File: rtl/tbu_param.sv
// Parametrised Viterbi traceback: trains over TB_LEN columns, then decodes DEC_LEN bits.
// Define TBU_PARAM_REVERSE_EN to emit the decoded bits in forward-time order via a LIFO.
module tbu_param import tbu_pkg::*; #(
  parameter int unsigned K       = DefK,
  parameter int unsigned DEPTH   = DefDepth,
  parameter int unsigned TB_LEN  = DefTbLen,
  parameter int unsigned DEC_LEN = DefDecLen
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic                     start,
  input  logic [K-2:0]             start_state,
  input  logic [$clog2(DEPTH)-1:0] start_col,
  output logic                     rd_en,
  output logic [$clog2(DEPTH)-1:0] rd_addr,
  input  logic [nstates(K)-1:0]    rd_data,
  output logic                     busy,
  output logic                     d_o,
  output logic                     d_o_valid,
  output logic                     done
);

  localparam int unsigned SW    = K - 1;
  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned Total = TB_LEN + DEC_LEN;
  localparam int unsigned CW    = $clog2(Total + 1);

  tbu_state_e    state_q, state_d;
  logic [SW-1:0] cur_state_q, cur_state_d;
  logic [AW-1:0] col_q, col_d;
  logic [CW-1:0] rd_cnt_q, rd_cnt_d;
  logic [CW-1:0] cons_cnt_q, cons_cnt_d;
  logic          rd_pend_q, rd_pend_d;
  logic          d_o_q, d_o_d;
  logic          valid_q, valid_d;
  logic          done_q, done_d;
  logic          consume, dec, out_bit;

`ifdef TBU_PARAM_REVERSE_EN
  logic push, pop, flush, lifo_top;

  tbu_lifo #(
    .DEPTH (DEC_LEN)
  ) u_lifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   (out_bit),
    .dout  (lifo_top)
  );
`endif

  assign busy    = (state_q != StIdle);
  assign rd_en   = enable && (state_q == StTrain || state_q == StDecode) &&
                   (rd_cnt_q < CW'(Total));
  assign rd_addr = rd_en ? col_q : '0;
  // Decision word returns one cycle after its read; enable low drops it.
  assign consume = enable && rd_pend_q;
  assign dec     = rd_data[cur_state_q];
  assign out_bit = cur_state_q[SW-1];

  always_comb begin
    state_d     = state_q;
    cur_state_d = cur_state_q;
    col_d       = col_q;
    rd_cnt_d    = rd_cnt_q;
    cons_cnt_d  = cons_cnt_q;
    rd_pend_d   = rd_en;
    d_o_d       = d_o_q;
    valid_d     = 1'b0;
    done_d      = 1'b0;
`ifdef TBU_PARAM_REVERSE_EN
    push        = 1'b0;
    pop         = 1'b0;
    flush       = 1'b0;
`endif

    unique case (state_q)
      StIdle: begin
        if (start && enable) begin
          state_d     = StTrain;
          cur_state_d = start_state;
          col_d       = start_col;
          rd_cnt_d    = '0;
          cons_cnt_d  = '0;
        end
      end

      StTrain, StDecode: begin
        if (rd_en) begin
          col_d    = col_q - 1'b1;
          rd_cnt_d = rd_cnt_q + 1'b1;
        end
        if (consume) begin
          cur_state_d = SW'(prev_state(MaxSw'(cur_state_q), dec));
          cons_cnt_d  = cons_cnt_q + 1'b1;
          if (state_q == StTrain) begin
            if (cons_cnt_q == CW'(TB_LEN - 1)) state_d = StDecode;
          end else begin
`ifdef TBU_PARAM_REVERSE_EN
            push = 1'b1;
            if (cons_cnt_q == CW'(Total - 1)) begin
              state_d    = StDrain;
              cons_cnt_d = '0;
            end
`else
            d_o_d   = out_bit;
            valid_d = 1'b1;
            if (cons_cnt_q == CW'(Total - 1)) begin
              state_d = StIdle;
              done_d  = 1'b1;
            end
`endif
          end
        end
      end

`ifdef TBU_PARAM_REVERSE_EN
      StDrain: begin
        pop        = 1'b1;
        d_o_d      = lifo_top;
        valid_d    = 1'b1;
        cons_cnt_d = cons_cnt_q + 1'b1;
        if (cons_cnt_q == CW'(DEC_LEN - 1)) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
`endif

      default: state_d = StIdle;
    endcase

    // Abort overrides everything: partial block is dropped silently.
    if (!enable && state_q != StIdle) begin
      state_d   = StIdle;
      rd_pend_d = 1'b0;
      d_o_d     = d_o_q;
      valid_d   = 1'b0;
      done_d    = 1'b0;
`ifdef TBU_PARAM_REVERSE_EN
      push      = 1'b0;
      pop       = 1'b0;
      flush     = 1'b1;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      cur_state_q <= '0;
      col_q       <= '0;
      rd_cnt_q    <= '0;
      cons_cnt_q  <= '0;
      rd_pend_q   <= 1'b0;
      d_o_q       <= 1'b0;
      valid_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_state_q <= cur_state_d;
      col_q       <= col_d;
      rd_cnt_q    <= rd_cnt_d;
      cons_cnt_q  <= cons_cnt_d;
      rd_pend_q   <= rd_pend_d;
      d_o_q       <= d_o_d;
      valid_q     <= valid_d;
      done_q      <= done_d;
    end
  end

  assign d_o       = d_o_q;
  assign d_o_valid = valid_q;
  assign done      = done_q;

endmodule
